// File: rtl/ysyx_24080014_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding and default geometry.
package ysyx_24080014_mc_ctrl_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          TIMEOUT_DEFAULT  = 255;

  // Encoding is visible to trace/difftest through state_o, so values are fixed.
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Width needed to count up to limit-1; a limit of 0 or 1 still gets one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ysyx_24080014_hs_timer.sv
// Handshake wait counter: counts enabled cycles since the last clear and flags the
// cycle on which the LIMIT-th wait occurs. LIMIT=0 never expires.
module ysyx_24080014_hs_timer
  import ysyx_24080014_mc_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the owner can leave its wait state on this very cycle.
  assign expire = (LIMIT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/ysyx_24080014_mc_ctrl.sv
// Multi-cycle sequencer: owns PC and instruction latch, sequences FETCH/EXEC/MEM/WB
// with variable-latency valid/ready buses and allows register writes only in WB.
module ysyx_24080014_mc_ctrl
  import ysyx_24080014_mc_ctrl_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  input  logic [31:0]     ifu_rdata,
  input  logic            is_load,
  input  logic            is_store,
  output logic            lsu_valid,
  input  logic            lsu_ready,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] next_pc,
  input  logic            reg_wen_in,
  input  logic            csr_wen_in,
  output logic            reg_wen,
  output logic            csr_wen,
  output logic            commit,
  output logic [2:0]      state_o,
  output logic            err
);

  state_t state;
  state_t state_nxt;
  logic   waiting;
  logic   expire;

  // A handshake is waiting only while its own valid is up and ready has not come.
  assign waiting = ((state == ST_FETCH) && !ifu_ready) ||
                   ((state == ST_MEM)   && !lsu_ready);

  ysyx_24080014_hs_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_nxt != state),
    .en     (waiting),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (ifu_ready)   state_nxt = ST_EXEC;
        else if (expire) state_nxt = ST_HALT;
      end
      ST_EXEC:  state_nxt = (is_load || is_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (lsu_ready)   state_nxt = ST_WB;
        else if (expire) state_nxt = ST_HALT;
      end
      ST_WB:    state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
    reg_wen   = 1'b0;
    csr_wen   = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_FETCH: ifu_valid = 1'b1;
      ST_MEM:   lsu_valid = 1'b1;
      ST_WB: begin
        reg_wen = reg_wen_in;
        csr_wen = csr_wen_in;
        commit  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath latches: each one moves only on its own accepted handshake or on WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      inst      <= '0;
      load_data <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == ST_FETCH) && ifu_ready)            inst      <= ifu_rdata;
      if ((state == ST_MEM) && lsu_ready && is_load)   load_data <= lsu_rdata;
      if (state == ST_WB)                              pc        <= next_pc;
      if (expire)                                      err       <= 1'b1;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_ysyx_24080014_mc_ctrl.sv
// Self-checking bench: directed and randomized instruction streams against a
// transaction-level model of latency, pulse counts and architectural state.
module tb_ysyx_24080014_mc_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default timeout
  logic        rst;
  logic [31:0] pc, inst, ifu_rdata, lsu_rdata, load_data, next_pc;
  logic        ifu_valid, ifu_ready, is_load, is_store, lsu_valid, lsu_ready;
  logic        reg_wen_in, csr_wen_in, reg_wen, csr_wen, commit, err;
  logic [2:0]  state_o;

  // Short-timeout instance
  logic        b_rst, b_ifu_ready, b_is_load, b_lsu_ready;
  logic [31:0] b_pc, b_inst, b_load_data;
  logic [31:0] b_ifu_rdata = 32'h0000_0013;
  logic [31:0] b_lsu_rdata = 32'h1234_5678;
  logic [31:0] b_next_pc   = 32'h8000_0004;
  logic        b_is_store  = 1'b0;
  logic        b_reg_wen_in = 1'b1;
  logic        b_csr_wen_in = 1'b0;
  logic        b_ifu_valid, b_lsu_valid, b_reg_wen, b_csr_wen, b_commit, b_err;
  logic [2:0]  b_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_inst, m_ld;

  ysyx_24080014_mc_ctrl #(.XLEN(32), .RESET_PC(RPC), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_rdata(ifu_rdata),
    .is_load(is_load), .is_store(is_store),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rdata(lsu_rdata),
    .load_data(load_data), .next_pc(next_pc),
    .reg_wen_in(reg_wen_in), .csr_wen_in(csr_wen_in),
    .reg_wen(reg_wen), .csr_wen(csr_wen), .commit(commit),
    .state_o(state_o), .err(err)
  );

  ysyx_24080014_mc_ctrl #(.XLEN(32), .RESET_PC(RPC), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst(b_rst), .pc(b_pc), .inst(b_inst),
    .ifu_valid(b_ifu_valid), .ifu_ready(b_ifu_ready), .ifu_rdata(b_ifu_rdata),
    .is_load(b_is_load), .is_store(b_is_store),
    .lsu_valid(b_lsu_valid), .lsu_ready(b_lsu_ready), .lsu_rdata(b_lsu_rdata),
    .load_data(b_load_data), .next_pc(b_next_pc),
    .reg_wen_in(b_reg_wen_in), .csr_wen_in(b_csr_wen_in),
    .reg_wen(b_reg_wen), .csr_wen(b_csr_wen), .commit(b_commit),
    .state_o(b_state), .err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its first FETCH cycle until just after its WB.
  // fw = fetch wait cycles, kind 0=alu 1=load 2=store, mw = memory wait cycles.
  task automatic run_instr(input string name, input logic [31:0] rdata, input int fw,
                           input int kind, input int mw, input logic [31:0] ldat,
                           input logic rw, input logic cw, input logic [31:0] npc);
    int cyc = 0, fcnt = 0, mcnt = 0, ivc = 0, lvc = 0, rwc = 0, cwc = 0, ccyc = 0;
    int exp_cyc;
    bit done = 0;
    is_load    = (kind == 1);
    is_store   = (kind == 2);
    reg_wen_in = rw;
    csr_wen_in = cw;
    next_pc    = npc;
    exp_cyc    = fw + 3 + ((kind != 0) ? mw + 1 : 0);
    while (!done && cyc < 200) begin
      cyc++;
      if (ifu_valid) begin
        ifu_ready = (fcnt == fw);
        ifu_rdata = (fcnt == fw) ? rdata : $urandom;
        fcnt++;
        ivc++;
      end else begin
        ifu_ready = 1'($urandom_range(0, 1));
        ifu_rdata = $urandom;
      end
      if (lsu_valid) begin
        lsu_ready = (mcnt == mw);
        lsu_rdata = (mcnt == mw) ? ldat : $urandom;
        mcnt++;
      end else begin
        lsu_ready = 1'($urandom_range(0, 1));
        lsu_rdata = $urandom;
      end
      #1;
      if (ifu_valid && !ifu_ready) chk({name, "_inst_hold"}, inst, m_inst);
      if (lsu_valid) lvc++;
      if (reg_wen) rwc++;
      if (csr_wen) cwc++;
      if (commit) begin
        done = 1;
        ccyc = cyc;
        chk({name, "_pc_at_commit"}, pc, m_pc);
        chk({name, "_inst"}, inst, rdata);
        chk({name, "_load_data"}, load_data, (kind == 1) ? ldat : m_ld);
        chk({name, "_reg_wen_wb"}, reg_wen, rw);
        chk({name, "_csr_wen_wb"}, csr_wen, cw);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk({name, "_commit_seen"}, done, 1);
    chk({name, "_latency"}, ccyc, exp_cyc);
    chk({name, "_ifu_valid_cycles"}, ivc, fw + 1);
    chk({name, "_lsu_valid_cycles"}, lvc, (kind != 0) ? mw + 1 : 0);
    chk({name, "_reg_wen_pulses"}, rwc, rw);
    chk({name, "_csr_wen_pulses"}, cwc, cw);
    m_inst = rdata;
    if (kind == 1) m_ld = ldat;
    m_pc = npc;
    tick();
    chk({name, "_pc_next"}, pc, m_pc);
    chk({name, "_back_to_fetch"}, state_o, 0);
    chk({name, "_commit_once"}, commit, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    ifu_ready = 0; ifu_rdata = 0; is_load = 0; is_store = 0;
    lsu_ready = 0; lsu_rdata = 0; next_pc = 0;
    reg_wen_in = 1; csr_wen_in = 1;
    b_ifu_ready = 0; b_is_load = 0; b_lsu_ready = 0;
    m_pc = RPC; m_inst = 0; m_ld = 0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_lsu_valid", lsu_valid, 0);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_commit", commit, 0);
    chk("rst_err", err, 0);
    chk("rst_state", state_o, 0);

    run_instr("addi", 32'h0010_0093, 0, 0, 0, 32'h0, 1, 0, m_pc + 32'd4);
    chk("addi_pc", pc, 32'h8000_0004);
    run_instr("stall", 32'h0020_8113, 5, 0, 0, 32'h0, 1, 1, m_pc + 32'd4);
    run_instr("load", 32'h0000_a183, 0, 1, 3, 32'hDEAD_BEEF, 1, 0, m_pc + 32'd4);
    run_instr("store", 32'h0030_a023, 1, 2, 2, 32'h5555_AAAA, 0, 0, m_pc + 32'd4);
    chk("store_keeps_load", load_data, 32'hDEAD_BEEF);

    for (int i = 0; i < 24; i++) begin
      int kind, fw, mw;
      logic [31:0] npc;
      kind = $urandom_range(0, 2);
      fw   = $urandom_range(0, 4);
      mw   = $urandom_range(0, 4);
      npc  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
      run_instr("rnd", $urandom, fw, kind, mw, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), npc);
    end

    run_instr("jump_top", 32'h0000_006f, 0, 0, 0, 32'h0, 1, 0, 32'hFFFF_FFFC);
    run_instr("wrap", 32'h0000_0013, 0, 0, 0, 32'h0, 0, 0, m_pc + 32'd4);
    chk("wrap_pc", pc, 32'h0);

    // Load held in MEM, then reset with a ready pending.
    run_instr("pre_abort", 32'h0000_2083, 0, 1, 0, 32'hCAFE_F00D, 1, 0, m_pc + 32'd4);
    is_load = 1; lsu_ready = 0;
    for (int k = 0; k < 20 && !lsu_valid; k++) begin
      ifu_ready = ifu_valid;
      ifu_rdata = 32'h0000_2083;
      lsu_ready = 0;
      #1;
      @(posedge clk);
      #1;
    end
    chk("abort_in_mem", lsu_valid, 1);
    rst = 1'b1; lsu_ready = 1'b1; lsu_rdata = 32'h7777_7777;
    tick();
    rst = 1'b0; lsu_ready = 1'b0; ifu_ready = 1'b0;
    #1;
    chk("abort_lsu_valid", lsu_valid, 0);
    chk("abort_state", state_o, 0);
    chk("abort_commit", commit, 0);
    chk("abort_pc", pc, RPC);
    chk("abort_load_data", load_data, 0);
    m_pc = RPC; m_inst = 0; m_ld = 0;
    run_instr("post_abort", 32'h0040_0193, 2, 0, 0, 32'h0, 1, 0, m_pc + 32'd4);

    // Fetch timeout on the short-timeout instance.
    b_rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_fetch_valid", b_ifu_valid, 1);
      chk("to_fetch_state", b_state, 0);
      chk("to_fetch_err", b_err, 0);
      tick();
    end
    chk("to_halt_state", b_state, 4);
    chk("to_halt_err", b_err, 1);
    chk("to_halt_ifu_valid", b_ifu_valid, 0);
    b_ifu_ready = 1'b1; b_lsu_ready = 1'b1;
    repeat (3) tick();
    chk("to_halt_sticky_state", b_state, 4);
    chk("to_halt_sticky_err", b_err, 1);
    chk("to_halt_no_commit", b_commit, 0);
    b_ifu_ready = 1'b0; b_lsu_ready = 1'b0;
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    #1;
    chk("to_rst_err", b_err, 0);
    chk("to_rst_pc", b_pc, RPC);
    chk("to_rst_state", b_state, 0);

    // Memory timeout: three fetch waits must not carry into the MEM count.
    repeat (3) tick();
    chk("tom_fetch_state", b_state, 0);
    b_ifu_ready = 1'b1; b_is_load = 1'b1;
    tick();
    b_ifu_ready = 1'b0;
    #1;
    chk("tom_exec_state", b_state, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("tom_mem_state", b_state, 2);
      chk("tom_mem_valid", b_lsu_valid, 1);
      chk("tom_mem_err", b_err, 0);
      tick();
    end
    chk("tom_halt_state", b_state, 4);
    chk("tom_halt_err", b_err, 1);
    chk("tom_halt_lsu_valid", b_lsu_valid, 0);
    chk("tom_halt_reg_wen", b_reg_wen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
